// File: rtl/display_pkg.sv
// Shared types and constants for the VGA output stage.
// Default 1024x768 timing, colour struct and test-bar palette.
package display_pkg;

    localparam int DEF_COLOR_W  = 4;

    localparam int DEF_H_ACTIVE = 1024;
    localparam int DEF_H_FP     = 24;
    localparam int DEF_H_SYNC   = 136;
    localparam int DEF_H_BP     = 160;
    localparam int DEF_V_ACTIVE = 768;
    localparam int DEF_V_FP     = 3;
    localparam int DEF_V_SYNC   = 6;
    localparam int DEF_V_BP     = 29;

    typedef struct packed {
        logic [DEF_COLOR_W-1:0] r;
        logic [DEF_COLOR_W-1:0] g;
        logic [DEF_COLOR_W-1:0] b;
    } rgb_t;

    // Bar colours as {r,g,b} on/off masks, expanded to full scale by the user.
    localparam logic [2:0] BAR_WHITE   = 3'b111;
    localparam logic [2:0] BAR_YELLOW  = 3'b110;
    localparam logic [2:0] BAR_CYAN    = 3'b011;
    localparam logic [2:0] BAR_GREEN   = 3'b010;
    localparam logic [2:0] BAR_MAGENTA = 3'b101;
    localparam logic [2:0] BAR_RED     = 3'b100;
    localparam logic [2:0] BAR_BLUE    = 3'b001;
    localparam logic [2:0] BAR_BLACK   = 3'b000;

    function automatic logic [2:0] bar_mask(input logic [2:0] idx);
        logic [2:0] m;
        m = BAR_BLACK;
        case (idx)
            3'd0:    m = BAR_WHITE;
            3'd1:    m = BAR_YELLOW;
            3'd2:    m = BAR_CYAN;
            3'd3:    m = BAR_GREEN;
            3'd4:    m = BAR_MAGENTA;
            3'd5:    m = BAR_RED;
            3'd6:    m = BAR_BLUE;
            default: m = BAR_BLACK;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters with raw active/sync flags and a frame-start pulse.
// frame_last_o marks the final clock of a frame (h,v at their maxima).
module vga_timing_gen
    import display_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW      = $clog2(H_TOTAL),
    localparam int VW      = $clog2(V_TOTAL)
)(
    input  logic          clk_i,
    input  logic          rst_ni,
    output logic [HW-1:0] hcount_o,
    output logic [VW-1:0] vcount_o,
    output logic          active_o,
    output logic          hs_n_o,
    output logic          vs_n_o,
    output logic          frame_start_o,
    output logic          frame_last_o
);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          fs_q, fs_d;
    logic          last;

    // Next raster position and the pulse that coincides with (0,0).
    always_comb begin
        h_d  = h_q + 1'b1;
        v_d  = v_q;
        last = (h_q == H_LAST) && (v_q == V_LAST);
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end
        fs_d = last;
    end

    // Counter and pulse registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            h_q  <= '0;
            v_q  <= '0;
            fs_q <= 1'b0;
        end else begin
            h_q  <= h_d;
            v_q  <= v_d;
            fs_q <= fs_d;
        end
    end

    assign hcount_o      = h_q;
    assign vcount_o      = v_q;
    assign frame_start_o = fs_q;
    assign frame_last_o  = last;
    assign active_o      = (32'(h_q) < H_ACTIVE) && (32'(v_q) < V_ACTIVE);
    assign hs_n_o        = !((32'(h_q) >= H_ACTIVE + H_FP) &&
                             (32'(h_q) <  H_ACTIVE + H_FP + H_SYNC));
    assign vs_n_o        = !((32'(v_q) >= V_ACTIVE + V_FP) &&
                             (32'(v_q) <  V_ACTIVE + V_FP + V_SYNC));

endmodule

// File: rtl/display_source_mux.sv
// VGA output stage: timing, frame-aligned source select, latency-matched sync.
// Optional TEST_PATTERN_EN adds an 8-bar pattern selectable as source NUM_SRC.
module display_source_mux
    import display_pkg::*;
#(
    parameter int NUM_SRC     = 4,
    parameter int COLOR_W     = DEF_COLOR_W,
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int H_FP        = DEF_H_FP,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BP        = DEF_H_BP,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int V_FP        = DEF_V_FP,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_BP        = DEF_V_BP,
    parameter int SRC_LATENCY = 2,
    localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW         = $clog2(H_TOTAL),
    localparam int VW         = $clog2(V_TOTAL),
    localparam int SEL_W      = $clog2(NUM_SRC + 1),
    localparam int PIX_W      = 3 * COLOR_W
)(
    input  logic                     clk_in,
    input  logic                     rst_in_n,
    input  logic [SEL_W-1:0]         sel_in,
    input  logic [NUM_SRC*PIX_W-1:0] pixel_in,
    output logic [HW-1:0]            hcount_out,
    output logic [VW-1:0]            vcount_out,
    output logic                     frame_start_out,
    output logic [SEL_W-1:0]         active_sel_out,
    output logic [COLOR_W-1:0]       vga_r,
    output logic [COLOR_W-1:0]       vga_g,
    output logic [COLOR_W-1:0]       vga_b,
    output logic                     vga_hs,
    output logic                     vga_vs
);

`ifdef TEST_PATTERN_EN
    localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(NUM_SRC);
`else
    localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(NUM_SRC - 1);
`endif

    typedef struct packed {
        logic             active;
        logic             hs_n;
        logic             vs_n;
        logic [SEL_W-1:0] sel;
`ifdef TEST_PATTERN_EN
        logic [HW-1:0]    hcnt;
`endif
    } tap_t;

    logic             active, hs_n, vs_n, frame_last;
    logic [SEL_W-1:0] sel_q, sel_d;
    tap_t             tap_now, tap_dly;
    logic [PIX_W-1:0] pix_q, pix_d;
    logic             hs_q, vs_q;

    vga_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk_i        (clk_in),
        .rst_ni       (rst_in_n),
        .hcount_o     (hcount_out),
        .vcount_o     (vcount_out),
        .active_o     (active),
        .hs_n_o       (hs_n),
        .vs_n_o       (vs_n),
        .frame_start_o(frame_start_out),
        .frame_last_o (frame_last)
    );

    // Accept a new source only on the last clock of a frame, if in range.
    always_comb begin
        sel_d = sel_q;
        if (frame_last && (sel_in <= SEL_MAX)) begin
            sel_d = sel_in;
        end
    end

    // Selection register; switches exactly as the counters hit (0,0).
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            sel_q <= '0;
        end else begin
            sel_q <= sel_d;
        end
    end

    assign active_sel_out = sel_q;

    // Bundle of counter-stage timing that travels alongside the sources.
    always_comb begin
        tap_now        = '0;
        tap_now.active = active;
        tap_now.hs_n   = hs_n;
        tap_now.vs_n   = vs_n;
        tap_now.sel    = sel_q;
`ifdef TEST_PATTERN_EN
        tap_now.hcnt   = hcount_out;
`endif
    end

    generate
        if (SRC_LATENCY == 0) begin : g_nodly
            assign tap_dly = tap_now;
        end else begin : g_dly
            tap_t sr_q [SRC_LATENCY];

            // Shift register matching the source pixel latency; syncs idle high.
            always_ff @(posedge clk_in or negedge rst_in_n) begin
                if (!rst_in_n) begin
                    for (int i = 0; i < SRC_LATENCY; i++) begin
                        sr_q[i]      <= '0;
                        sr_q[i].hs_n <= 1'b1;
                        sr_q[i].vs_n <= 1'b1;
                    end
                end else begin
                    sr_q[0] <= tap_now;
                    for (int i = 1; i < SRC_LATENCY; i++) begin
                        sr_q[i] <= sr_q[i-1];
                    end
                end
            end

            assign tap_dly = sr_q[SRC_LATENCY-1];
        end
    endgenerate

`ifdef TEST_PATTERN_EN
    logic [2:0] bar_idx, bar_m;
    assign bar_idx = 3'((32'(tap_dly.hcnt) * 8) / H_ACTIVE);
    assign bar_m   = bar_mask(bar_idx);
`endif

    // Pick the delayed source's pixel; black outside the active area.
    always_comb begin
        pix_d = '0;
        if (tap_dly.active) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (tap_dly.sel == SEL_W'(i)) begin
                    pix_d = pixel_in[i*PIX_W +: PIX_W];
                end
            end
`ifdef TEST_PATTERN_EN
            if (tap_dly.sel == SEL_W'(NUM_SRC)) begin
                pix_d = {{COLOR_W{bar_m[2]}},
                         {COLOR_W{bar_m[1]}},
                         {COLOR_W{bar_m[0]}}};
            end
`endif
        end
    end

    // Output register stage driving the pins.
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            pix_q <= '0;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
        end else begin
            pix_q <= pix_d;
            hs_q  <= tap_dly.hs_n;
            vs_q  <= tap_dly.vs_n;
        end
    end

    assign vga_r  = pix_q[3*COLOR_W-1 -: COLOR_W];
    assign vga_g  = pix_q[2*COLOR_W-1 -: COLOR_W];
    assign vga_b  = pix_q[COLOR_W-1:0];
    assign vga_hs = hs_q;
    assign vga_vs = vs_q;

endmodule

// File: tb/tb_display_source_mux.sv
// Directed bench for display_source_mux on a 12x7 raster, latency 2.
// Pattern checks are active when TEST_PATTERN_EN is defined.
module tb_display_source_mux;

    localparam int NUM_SRC = 4;
    localparam int COLOR_W = 4;
    localparam int SEL_W   = 3;
    localparam int HW      = 4;
    localparam int VW      = 3;
    localparam int LINE    = 12;
    localparam int FRAME   = 84;

    logic                         clk = 1'b0;
    logic                         rst_n = 1'b0;
    logic [SEL_W-1:0]             sel = '0;
    logic [NUM_SRC*3*COLOR_W-1:0] pix;
    logic [HW-1:0]                hcnt;
    logic [VW-1:0]                vcnt;
    logic                         fs;
    logic [SEL_W-1:0]             asel;
    logic [COLOR_W-1:0]           r, g, b;
    logic                         hs, vs;
    logic                         lat_mode = 1'b0;
    logic [HW-1:0]                hq1, hq2;
    logic [11:0]                  rgb;

    int n_cmp = 0;
    int n_bad = 0;

    display_source_mux #(
        .NUM_SRC(NUM_SRC), .COLOR_W(COLOR_W),
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SRC_LATENCY(2)
    ) dut (
        .clk_in         (clk),
        .rst_in_n       (rst_n),
        .sel_in         (sel),
        .pixel_in       (pix),
        .hcount_out     (hcnt),
        .vcount_out     (vcnt),
        .frame_start_out(fs),
        .active_sel_out (asel),
        .vga_r          (r),
        .vga_g          (g),
        .vga_b          (b),
        .vga_hs         (hs),
        .vga_vs         (vs)
    );

    always #5 clk = ~clk;

    // Source 1 model: echoes hcount two clocks later in latency mode.
    always @(posedge clk) begin
        hq1 <= hcnt;
        hq2 <= hq1;
    end

    always_comb begin
        pix = {12'h444, 12'h333,
               (lat_mode ? {hq2, hq2, hq2} : 12'h222),
               12'h111};
    end

    assign rgb = {r, g, b};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_pos(input int h, input int v);
        int k;
        k = 0;
        while (!(int'(hcnt) == h && int'(vcnt) == v) && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk($sformatf("reach_%0d_%0d", h, v),
            32'(int'(hcnt) == h && int'(vcnt) == v), 32'd1);
    endtask

    initial begin
        int hs_lo, vs_lo, fs_n, hs_bad, vs_bad, fs_bad, bad, good, k, p;
        logic [11:0] bars [8];
        bars = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                 12'hF0F, 12'hF00, 12'h00F, 12'h000};

        // Reset state
        step(3);
        chk("rst0_h", 32'(hcnt), 0);
        chk("rst0_v", 32'(vcnt), 0);
        chk("rst0_fs", 32'(fs), 0);
        chk("rst0_sel", 32'(asel), 0);
        chk("rst0_rgb", 32'(rgb), 0);
        chk("rst0_hs", 32'(hs), 1);
        chk("rst0_vs", 32'(vs), 1);

        // Reset mid-frame at (5,2) with a non-zero selection live
        rst_n = 1'b1;
        sel   = 3'd3;
        wait_pos(5, 2);
        step(1);
        wait_pos(5, 2);
        chk("pre_rst_sel", 32'(asel), 3);
        rst_n = 1'b0;
        sel   = 3'd0;
        #1;
        chk("mid_rst_h", 32'(hcnt), 0);
        chk("mid_rst_v", 32'(vcnt), 0);
        chk("mid_rst_sel", 32'(asel), 0);
        chk("mid_rst_hs", 32'(hs), 1);
        chk("mid_rst_vs", 32'(vs), 1);
        chk("mid_rst_rgb", 32'(rgb), 0);
        step(2);
        rst_n = 1'b1;
        chk("rel_h", 32'(hcnt), 0);
        chk("rel_v", 32'(vcnt), 0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("refill_rgb_%0d", i), 32'(rgb), 0);
            chk($sformatf("refill_hs_%0d", i), 32'(hs), 1);
            chk($sformatf("refill_vs_%0d", i), 32'(vs), 1);
            step(1);
        end
        chk("refill_h", 32'(hcnt), 3);
        chk("first_px", 32'(rgb), 32'h111);

        // Timing over two frames
        step(1);
        wait_pos(0, 0);
        hs_lo = 0; vs_lo = 0; fs_n = 0;
        hs_bad = 0; vs_bad = 0; fs_bad = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            p = int'(vcnt) * LINE + int'(hcnt);
            if (!hs) begin
                hs_lo++;
                if (!(hcnt == 4'd0 || hcnt == 4'd1)) hs_bad++;
            end
            if (!vs) begin
                vs_lo++;
                if (p < 63 || p > 74) vs_bad++;
            end
            if (fs) fs_n++;
            if (fs != (p == 0)) fs_bad++;
            step(1);
        end
        chk("hs_low_cnt", 32'(hs_lo), 28);
        chk("hs_low_pos", 32'(hs_bad), 0);
        chk("vs_low_cnt", 32'(vs_lo), 24);
        chk("vs_low_pos", 32'(vs_bad), 0);
        chk("fs_cnt", 32'(fs_n), 2);
        chk("fs_pos", 32'(fs_bad), 0);

        // Source switch requested mid-frame
        wait_pos(3, 1);
        sel = 3'd2;
        bad = 0;
        k   = 0;
        step(1);
        while (!(hcnt == 4'd3 && vcnt == 3'd0) && k < 200) begin
            if (rgb != 12'h000 && rgb != 12'h111) bad++;
            if (hcnt == 4'd10 && vcnt == 3'd3)
                chk("sw_last_px", 32'(rgb), 32'h111);
            if (hcnt == 4'd11 && vcnt == 3'd6)
                chk("sw_hold_sel", 32'(asel), 0);
            step(1);
            k++;
        end
        chk("sw_old_frame", 32'(bad), 0);
        chk("sw_new_sel", 32'(asel), 2);
        chk("sw_first_px", 32'(rgb), 32'h333);
        bad = 0; good = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (rgb == 12'h333) good++;
            else if (rgb != 12'h000) bad++;
            step(1);
        end
        chk("sw_new_good", 32'(good), 32);
        chk("sw_new_bad", 32'(bad), 0);

        // Out-of-range request is ignored
        sel = 3'd5;
        bad = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            if (asel != 3'd2) bad++;
            step(1);
        end
        chk("oor_hold", 32'(bad), 0);
        chk("oor_sel", 32'(asel), 2);

        // Latency: source 1 echoes its column
        lat_mode = 1'b1;
        sel = 3'd1;
        step(1);
        wait_pos(0, 0);
        chk("lat_sel", 32'(asel), 1);
        wait_pos(5, 1);
        step(3);
        chk("lat_c5", 32'(rgb), 32'h555);
        wait_pos(9, 1);
        step(3);
        chk("lat_blank_col", 32'(rgb), 0);
        wait_pos(7, 2);
        step(2);
        chk("lat_c7_early", 32'(rgb), 32'h666);
        step(1);
        chk("lat_c7", 32'(rgb), 32'h777);
        wait_pos(3, 4);
        step(3);
        chk("lat_blank_line", 32'(rgb), 0);

`ifdef TEST_PATTERN_EN
        sel = 3'd4;
        step(1);
        wait_pos(0, 0);
        chk("pat_sel", 32'(asel), 4);
        wait_pos(0, 1);
        step(3);
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("pat_c%0d", c), 32'(rgb), 32'(bars[c]));
            step(1);
        end
`else
        sel = 3'd4;
        step(1);
        wait_pos(0, 0);
        step(1);
        chk("nopat_sel", 32'(asel), 1);
        chk("nopat_bars", 32'(bars[0]), 32'hFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
